// File: rtl/book_msg_scheduler_pkg.sv
// Shared types and constants for the order-book update scheduler.
package book_msg_scheduler_pkg;

  typedef struct packed {
    logic [15:0] locate;
    logic [31:0] price;
    logic [31:0] shares;
    logic        buySell;
  } book_msg_t;

  localparam logic SIDE_SELL = 1'b0;
  localparam logic SIDE_BUY  = 1'b1;

  // order_book holds a side for two level read-back stages plus one update stage.
  localparam int unsigned HAZARD_CYCLES_C = 3;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ADD,
    GRANT_DEL
  } grant_e;

endpackage

// File: rtl/book_msg_fifo.sv
// Single-clock FIFO of book messages with registered storage and no bypass.
module book_msg_fifo
  import book_msg_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clkIn,
  input  logic      rstNIn,
  input  logic      push,
  input  book_msg_t pushData,
  input  logic      pop,
  output book_msg_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = CNT_W'(DEPTH);

  book_msg_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/book_msg_scheduler.sv
// Buffers add and del/exec streams, arbitrates round-robin and spaces
// same-side updates so the order_book RMW pipeline never sees a side hazard.
module book_msg_scheduler
  import book_msg_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HAZARD_CYCLES = HAZARD_CYCLES_C
) (
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic        enableIn,
  input  logic        addValidIn,
  output logic        addReadyOut,
  input  logic [15:0] addLocateIn,
  input  logic [31:0] addPriceIn,
  input  logic [31:0] addSharesIn,
  input  logic        addBuySellIn,
  input  logic        delValidIn,
  output logic        delReadyOut,
  input  logic [15:0] delLocateIn,
  input  logic [31:0] delPriceIn,
  input  logic [31:0] delSharesIn,
  input  logic        delBuySellIn,
  output logic        addValidOut,
  output logic [15:0] locateOut,
  output logic [31:0] priceOut,
  output logic [31:0] sharesOut,
  output logic        buySellOut,
  output logic        delExecValidOut,
  output logic [15:0] mapLocateOut,
  output logic [31:0] mapPriceOut,
  output logic [31:0] mapSharesOut,
  output logic        mapBuySellOut,
  output logic [31:0] issueCountOut,
  output logic [31:0] stallCountOut
);

  localparam int unsigned HW = $clog2(HAZARD_CYCLES + 1);
  localparam logic [HW-1:0] HAZ_LOAD = HW'(HAZARD_CYCLES - 1);

  book_msg_t addIn, delIn, addHead, delHead, addOut, delOut;
  logic      addFull, addEmpty, delFull, delEmpty;
  logic      addPop, delPop;
  logic      addBlocked, delBlocked, addElig, delElig;
  logic      stallCond, issuing, issueSide;
  logic      lastAdd;
  grant_e    grant;
  logic [HW-1:0] hazCnt [2];

  assign addIn = '{locate: addLocateIn, price: addPriceIn, shares: addSharesIn, buySell: addBuySellIn};
  assign delIn = '{locate: delLocateIn, price: delPriceIn, shares: delSharesIn, buySell: delBuySellIn};

  book_msg_fifo #(.DEPTH(FIFO_DEPTH)) addFifo (
    .clkIn    (clkIn),
    .rstNIn   (rstNIn),
    .push     (addValidIn),
    .pushData (addIn),
    .pop      (addPop),
    .head     (addHead),
    .full     (addFull),
    .empty    (addEmpty)
  );

  book_msg_fifo #(.DEPTH(FIFO_DEPTH)) delFifo (
    .clkIn    (clkIn),
    .rstNIn   (rstNIn),
    .push     (delValidIn),
    .pushData (delIn),
    .pop      (delPop),
    .head     (delHead),
    .full     (delFull),
    .empty    (delEmpty)
  );

  assign addReadyOut = !addFull;
  assign delReadyOut = !delFull;

  assign addBlocked = (hazCnt[addHead.buySell] != '0);
  assign delBlocked = (hazCnt[delHead.buySell] != '0);
  assign addElig    = !addEmpty && enableIn && !addBlocked;
  assign delElig    = !delEmpty && enableIn && !delBlocked;

  // Stall only when enabled work exists and every occupied head waits on a hazard.
  assign stallCond = enableIn && (!addEmpty || !delEmpty) &&
                     (addEmpty || addBlocked) && (delEmpty || delBlocked);

  always_comb begin
    grant = GRANT_NONE;
    if (addElig && delElig) grant = lastAdd ? GRANT_DEL : GRANT_ADD;
    else if (addElig)       grant = GRANT_ADD;
    else if (delElig)       grant = GRANT_DEL;
  end

  assign addPop    = (grant == GRANT_ADD);
  assign delPop    = (grant == GRANT_DEL);
  assign issuing   = (grant != GRANT_NONE);
  assign issueSide = addPop ? addHead.buySell : delHead.buySell;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      addValidOut     <= 1'b0;
      delExecValidOut <= 1'b0;
      addOut          <= '0;
      delOut          <= '0;
      issueCountOut   <= '0;
      stallCountOut   <= '0;
      lastAdd         <= 1'b1;
      for (int unsigned s = 0; s < 2; s++) hazCnt[s] <= '0;
    end else begin
      addValidOut     <= addPop;
      delExecValidOut <= delPop;
      if (addPop) addOut <= addHead;
      if (delPop) delOut <= delHead;
      if (issuing) begin
        issueCountOut <= issueCountOut + 32'd1;
        lastAdd       <= addPop;
      end
      if (stallCond && (stallCountOut != '1)) stallCountOut <= stallCountOut + 32'd1;
      for (int unsigned s = 0; s < 2; s++) begin
        if (issuing && (issueSide == 1'(s))) hazCnt[s] <= HAZ_LOAD;
        else if (hazCnt[s] != '0)             hazCnt[s] <= hazCnt[s] - 1'b1;
      end
    end
  end

  assign locateOut     = addOut.locate;
  assign priceOut      = addOut.price;
  assign sharesOut     = addOut.shares;
  assign buySellOut    = addOut.buySell;
  assign mapLocateOut  = delOut.locate;
  assign mapPriceOut   = delOut.price;
  assign mapSharesOut  = delOut.shares;
  assign mapBuySellOut = delOut.buySell;

endmodule
